// File: rtl/rocketcpu_wb_param_loader.sv
// rocketcpu_wb_param_loader: Wishbone initiator moving a block of 32-bit words
// between a local valid/ready stream and a Wishbone responder.
module rocketcpu_wb_param_loader #(
    parameter logic [31:0] DEF_BASE = 32'h1000_0000,
    parameter int          TIMEOUT  = 64,
    parameter int          CNT_W    = 6
) (
    input  logic             i_wb_clk,
    input  logic             i_wb_rst_n,
    input  logic             i_start,
    input  logic             i_dir,
    input  logic [CNT_W-1:0] i_count,
    input  logic             i_base_sel,
    input  logic [31:0]      i_base,
    input  logic [31:0]      i_wr_data,
    input  logic             i_wr_valid,
    output logic             o_wr_ready,
    output logic [31:0]      o_rd_data,
    output logic             o_rd_valid,
    input  logic             i_rd_ready,
    output logic [31:0]      o_wb_adr,
    output logic [31:0]      o_wb_dat,
    output logic [3:0]       o_wb_sel,
    output logic             o_wb_we,
    output logic             o_wb_cyc,
    input  logic [31:0]      i_wb_rdt,
    input  logic             i_wb_ack,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_timeout
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, FETCH, BUS, GAP, DELIVER} state_t;

    state_t           state_q;
    logic             dir_q, cyc_q, we_q, ready_q, valid_q, busy_q, done_q, timeout_q;
    logic [CNT_W-1:0] rem_q;
    logic [31:0]      adr_q, dat_q, rd_data_q;
    logic [TW-1:0]    tmo_q;
    logic [31:0]      base_d;

    assign base_d = i_base_sel ? {i_base[31:2], 2'b00} : DEF_BASE;

    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            state_q   <= IDLE;
            dir_q     <= 1'b0;
            cyc_q     <= 1'b0;
            we_q      <= 1'b0;
            ready_q   <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            rem_q     <= '0;
            adr_q     <= '0;
            dat_q     <= '0;
            rd_data_q <= '0;
            tmo_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (i_start) begin
                    dir_q     <= i_dir;
                    rem_q     <= i_count;
                    adr_q     <= base_d;
                    timeout_q <= 1'b0;
                    if (i_count == '0) begin
                        done_q <= 1'b1;
                    end else begin
                        busy_q <= 1'b1;
                        if (i_dir) begin
                            state_q <= BUS;
                            cyc_q   <= 1'b1;
                            we_q    <= 1'b0;
                            tmo_q   <= '0;
                        end else begin
                            state_q <= FETCH;
                            ready_q <= 1'b1;
                        end
                    end
                end
                FETCH: if (i_wr_valid) begin
                    dat_q   <= i_wr_data;
                    ready_q <= 1'b0;
                    cyc_q   <= 1'b1;
                    we_q    <= 1'b1;
                    tmo_q   <= '0;
                    state_q <= BUS;
                end
                BUS: begin
                    // ack wins over a timeout expiring in the same cycle
                    if (i_wb_ack) begin
                        cyc_q <= 1'b0;
                        we_q  <= 1'b0;
                        if (dir_q) begin
                            rd_data_q <= i_wb_rdt;
                            valid_q   <= 1'b1;
                            state_q   <= DELIVER;
                        end else begin
                            state_q <= GAP;
                        end
                    end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                        cyc_q     <= 1'b0;
                        we_q      <= 1'b0;
                        timeout_q <= 1'b1;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                DELIVER: if (i_rd_ready) begin
                    valid_q <= 1'b0;
                    state_q <= GAP;
                end
                GAP: begin
                    adr_q <= adr_q + 32'd4;
                    rem_q <= rem_q - 1'b1;
                    if (rem_q == CNT_W'(1)) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (dir_q) begin
                        cyc_q   <= 1'b1;
                        we_q    <= 1'b0;
                        tmo_q   <= '0;
                        state_q <= BUS;
                    end else begin
                        ready_q <= 1'b1;
                        state_q <= FETCH;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_wr_ready = ready_q;
    assign o_rd_data  = rd_data_q;
    assign o_rd_valid = valid_q;
    assign o_wb_adr   = adr_q;
    assign o_wb_dat   = dat_q;
    assign o_wb_sel   = {4{cyc_q}};
    assign o_wb_we    = we_q;
    assign o_wb_cyc   = cyc_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_timeout  = timeout_q;
endmodule

// File: tb/tb_rocketcpu_wb_param_loader.sv
// tb_rocketcpu_wb_param_loader: directed bench with a 2-cycle-ack responder model
// and a stream source; each task checks its own scenario inline.
module tb_rocketcpu_wb_param_loader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_start = 1'b0, i_dir = 1'b0, i_base_sel = 1'b0, i_rd_ready = 1'b0;
    logic [5:0]  i_count = '0;
    logic [31:0] i_base = '0;
    logic [31:0] i_wr_data, o_rd_data, o_wb_adr, o_wb_dat, i_wb_rdt;
    logic        i_wr_valid, o_wr_ready, o_rd_valid, o_wb_we, o_wb_cyc;
    logic        o_busy, o_done, o_timeout;
    logic [3:0]  o_wb_sel;
    logic        ack = 1'b0;

    int passed = 0, total = 0;

    rocketcpu_wb_param_loader dut (
        .i_wb_clk(clk), .i_wb_rst_n(rst_n), .i_start(i_start), .i_dir(i_dir),
        .i_count(i_count), .i_base_sel(i_base_sel), .i_base(i_base),
        .i_wr_data(i_wr_data), .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready),
        .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid), .i_rd_ready(i_rd_ready),
        .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat), .o_wb_sel(o_wb_sel), .o_wb_we(o_wb_we),
        .o_wb_cyc(o_wb_cyc), .i_wb_rdt(i_wb_rdt), .i_wb_ack(ack), .o_busy(o_busy),
        .o_done(o_done), .o_timeout(o_timeout)
    );

    always #5 clk = ~clk;

    // responder: ack two cycles after cyc rises; read data derived from address
    bit          resp_en = 1'b1;
    logic [1:0]  wcnt = '0;
    assign i_wb_rdt = o_wb_adr ^ 32'hA5A5_0000;
    always @(posedge clk) begin
        if (resp_en && o_wb_cyc && !ack) begin
            if (wcnt == 2'd1) ack <= 1'b1;
            else wcnt <= wcnt + 2'd1;
        end else begin
            ack  <= 1'b0;
            wcnt <= '0;
        end
    end

    logic [31:0] log_adr[64], log_dat[64];
    logic        log_we[64];
    logic [3:0]  log_sel[64];
    int          wn = 0, done_cnt = 0, rises = 0, cyc_hi = 0;
    logic        cyc_prev = 1'b0;
    always @(posedge clk) begin
        if (o_wb_cyc && ack) begin
            log_adr[wn] <= o_wb_adr;
            log_dat[wn] <= o_wb_dat;
            log_we[wn]  <= o_wb_we;
            log_sel[wn] <= o_wb_sel;
            wn <= wn + 1;
        end
        if (o_done) done_cnt <= done_cnt + 1;
        if (o_wb_cyc) cyc_hi <= cyc_hi + 1;
        if (o_wb_cyc && !cyc_prev) rises <= rises + 1;
        cyc_prev <= o_wb_cyc;
    end

    // write-stream source, optionally valid only every third cycle
    logic [31:0] src_mem[8];
    logic [3:0]  src_idx = '0, src_n = '0;
    bit          src_load = 1'b0, gapped = 1'b0;
    int          phase = 0;
    assign i_wr_valid = (src_idx < src_n) && (!gapped || phase == 0);
    assign i_wr_data  = src_mem[src_idx[2:0]];
    always @(posedge clk) begin
        phase <= (phase == 2) ? 0 : phase + 1;
        if (src_load) src_idx <= '0;
        else if (i_wr_valid && o_wr_ready) src_idx <= src_idx + 4'd1;
    end

    task automatic load_src(input logic [31:0] a, b, c, d, input logic [3:0] n);
        src_mem[0] = a; src_mem[1] = b; src_mem[2] = c; src_mem[3] = d;
        src_n = n;
        src_load = 1'b1;
        @(posedge clk); #1 src_load = 1'b0;
    endtask

    task automatic start(input logic dir, input logic [5:0] cnt, input logic bsel, input logic [31:0] base);
        i_dir = dir; i_count = cnt; i_base_sel = bsel; i_base = base; i_start = 1'b1;
        @(posedge clk); #1 i_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int lat);
        lat = 0;
        do begin @(negedge clk); lat++; end while (!o_done && lat < budget);
        if (!o_done) $display("FAIL wait_done: no o_done within %0d cycles", budget);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++; if ({o_wb_cyc, o_busy, o_done, o_timeout, o_wr_ready, o_rd_valid, o_wb_we} !== 7'b0)
            $display("FAIL reset_ctl: got %b want 0", {o_wb_cyc, o_busy, o_done, o_timeout, o_wr_ready, o_rd_valid, o_wb_we});
        else passed++;
        total++; if ({o_wb_adr, o_wb_dat, o_rd_data, o_wb_sel} !== 100'b0)
            $display("FAIL reset_data: adr %h dat %h rd %h sel %h want 0", o_wb_adr, o_wb_dat, o_rd_data, o_wb_sel);
        else passed++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write3();
        int n0 = wn, d0 = done_cnt, r0 = rises, h0 = cyc_hi, lat;
        load_src(32'hA, 32'hB, 32'hC, 32'h0, 4'd3);
        @(negedge clk);
        start(1'b0, 6'd3, 1'b0, 32'hFFFF_FFFF);
        wait_done(60, lat);
        total++; if (lat !== 16) $display("FAIL w3_latency: got %0d want 16", lat); else passed++;
        total++; if (o_busy !== 1'b0 || o_timeout !== 1'b0)
            $display("FAIL w3_flags: busy %b timeout %b want 0 0", o_busy, o_timeout);
        else passed++;
        @(negedge clk);
        total++; if (wn - n0 !== 3) $display("FAIL w3_count: got %0d want 3", wn - n0); else passed++;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (log_adr[n0+i] !== 32'h1000_0000 + 32'(4*i) || log_dat[n0+i] !== 32'hA + 32'(i) || log_we[n0+i] !== 1'b1 || log_sel[n0+i] !== 4'hF)
                $display("FAIL w3_word%0d: adr %h dat %h we %b sel %h want %h %h 1 f", i, log_adr[n0+i], log_dat[n0+i], log_we[n0+i], log_sel[n0+i], 32'h1000_0000 + 32'(4*i), 32'hA + 32'(i));
            else passed++;
        end
        total++; if (rises - r0 !== 3 || cyc_hi - h0 !== 9)
            $display("FAIL w3_cyc: rises %0d high %0d want 3 9", rises - r0, cyc_hi - h0);
        else passed++;
        total++; if (done_cnt - d0 !== 1) $display("FAIL w3_done: got %0d want 1", done_cnt - d0); else passed++;
    endtask

    task automatic test_read2();
        int n0 = wn, lat, k;
        bit stable = 1'b1;
        @(negedge clk);
        start(1'b1, 6'd2, 1'b1, 32'h1000_0012);
        k = 0;
        do begin @(negedge clk); k++; end while (!o_rd_valid && k < 20);
        total++; if (o_rd_valid !== 1'b1 || o_rd_data !== 32'hB5A5_0010)
            $display("FAIL r2_first: valid %b data %h want 1 b5a50010", o_rd_valid, o_rd_data);
        else passed++;
        repeat (5) begin
            @(negedge clk);
            if (o_rd_valid !== 1'b1 || o_rd_data !== 32'hB5A5_0010 || o_wb_cyc !== 1'b0) stable = 1'b0;
        end
        total++; if (!stable) $display("FAIL r2_hold: valid %b data %h cyc %b want 1 b5a50010 0", o_rd_valid, o_rd_data, o_wb_cyc);
        else passed++;
        i_rd_ready = 1'b1;
        @(posedge clk); #1 i_rd_ready = 1'b0;
        k = 0;
        do begin @(negedge clk); k++; end while (!o_rd_valid && k < 20);
        total++; if (o_rd_valid !== 1'b1 || o_rd_data !== 32'hB5A5_0014)
            $display("FAIL r2_second: valid %b data %h want 1 b5a50014", o_rd_valid, o_rd_data);
        else passed++;
        i_rd_ready = 1'b1;
        wait_done(20, lat);
        i_rd_ready = 1'b0;
        @(negedge clk);
        total++; if (wn - n0 !== 2 || log_adr[n0] !== 32'h1000_0010 || log_adr[n0+1] !== 32'h1000_0014 || log_we[n0] !== 1'b0)
            $display("FAIL r2_bus: n %0d adr0 %h adr1 %h we %b want 2 10000010 10000014 0", wn - n0, log_adr[n0], log_adr[n0+1], log_we[n0]);
        else passed++;
    endtask

    task automatic test_timeout();
        int n0 = wn, d0 = done_cnt, h0 = cyc_hi, lat;
        resp_en = 1'b0;
        load_src(32'h11, 32'h22, 32'h0, 32'h0, 4'd2);
        @(negedge clk);
        start(1'b0, 6'd2, 1'b0, 32'h0);
        wait_done(200, lat);
        total++; if (o_timeout !== 1'b1 || o_busy !== 1'b0 || o_wb_cyc !== 1'b0)
            $display("FAIL to_flags: timeout %b busy %b cyc %b want 1 0 0", o_timeout, o_busy, o_wb_cyc);
        else passed++;
        @(negedge clk);
        total++; if (cyc_hi - h0 !== 64) $display("FAIL to_cyc_len: got %0d want 64", cyc_hi - h0); else passed++;
        total++; if (done_cnt - d0 !== 1 || wn - n0 !== 0 || o_wr_ready !== 1'b0)
            $display("FAIL to_done: done %0d writes %0d ready %b want 1 0 0", done_cnt - d0, wn - n0, o_wr_ready);
        else passed++;
        resp_en = 1'b1;
    endtask

    task automatic test_count0();
        int r0 = rises;
        @(negedge clk);
        start(1'b0, 6'd0, 1'b0, 32'h0);
        @(negedge clk);
        total++; if (o_done !== 1'b1 || o_timeout !== 1'b0)
            $display("FAIL c0_done: done %b timeout %b want 1 0", o_done, o_timeout);
        else passed++;
        @(negedge clk);
        total++; if (o_done !== 1'b0 || rises !== r0)
            $display("FAIL c0_after: done %b cyc rises %0d want 0 0", o_done, rises - r0);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int n0 = wn, d0 = done_cnt, lat;
        bit ok = 1'b1;
        load_src(32'h100, 32'h200, 32'h300, 32'h400, 4'd4);
        @(negedge clk);
        start(1'b0, 6'd4, 1'b0, 32'h0);
        repeat (6) @(negedge clk);
        start(1'b1, 6'd1, 1'b1, 32'h2000_0000);
        wait_done(60, lat);
        @(negedge clk);
        total++; if (wn - n0 !== 4 || done_cnt - d0 !== 1)
            $display("FAIL b2b_count: writes %0d done %0d want 4 1", wn - n0, done_cnt - d0);
        else passed++;
        for (int i = 0; i < 4; i++)
            if (log_adr[n0+i] !== 32'h1000_0000 + 32'(4*i) || log_dat[n0+i] !== 32'(256*(i+1)) || log_we[n0+i] !== 1'b1) ok = 1'b0;
        total++; if (!ok) $display("FAIL b2b_words: last adr %h dat %h want 1000000c 00000400", log_adr[n0+3], log_dat[n0+3]);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int n0, k, lat;
        load_src(32'h5, 32'h6, 32'h7, 32'h0, 4'd3);
        @(negedge clk);
        start(1'b0, 6'd3, 1'b0, 32'h0);
        k = 0;
        do begin @(negedge clk); k++; end while (!o_wb_cyc && k < 10);
        rst_n = 1'b0;
        #1;
        total++; if ({o_wb_cyc, o_busy, o_rd_valid, o_wr_ready} !== 4'b0)
            $display("FAIL rst_mid: cyc %b busy %b valid %b ready %b want 0", o_wb_cyc, o_busy, o_rd_valid, o_wr_ready);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        n0 = wn;
        load_src(32'h1234, 32'h0, 32'h0, 32'h0, 4'd1);
        @(negedge clk);
        start(1'b0, 6'd1, 1'b1, 32'h0000_0103);
        wait_done(20, lat);
        @(negedge clk);
        total++; if (wn - n0 !== 1 || log_adr[n0] !== 32'h100 || log_dat[n0] !== 32'h1234)
            $display("FAIL rst_after: n %0d adr %h dat %h want 1 00000100 00001234", wn - n0, log_adr[n0], log_dat[n0]);
        else passed++;
    endtask

    task automatic test_gapped();
        int n0 = wn, lat;
        gapped = 1'b1;
        load_src(32'hD1, 32'hD2, 32'hD3, 32'h0, 4'd3);
        @(negedge clk);
        start(1'b0, 6'd3, 1'b0, 32'h0);
        wait_done(100, lat);
        @(negedge clk);
        total++; if (wn - n0 !== 3 || log_dat[n0] !== 32'hD1 || log_dat[n0+1] !== 32'hD2 || log_dat[n0+2] !== 32'hD3)
            $display("FAIL gap_order: n %0d dat %h %h %h want 3 d1 d2 d3", wn - n0, log_dat[n0], log_dat[n0+1], log_dat[n0+2]);
        else passed++;
        total++; if (log_adr[n0+2] !== 32'h1000_0008) $display("FAIL gap_adr: got %h want 10000008", log_adr[n0+2]);
        else passed++;
        gapped = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write3();
        test_read2();
        test_timeout();
        test_count0();
        test_back_to_back();
        test_reset_mid();
        test_gapped();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
